// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and decode helpers for the load/store accessor.
//   lsu_op_t    - memory operation code carried on in_op
//   lsu_fault_t - fault code reported on out_fault
//   lsu_state_t - accessor FSM state
//   op_size / op_is_signed / op_is_load / op_is_store / op_is_legal
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LD   = 4'd4,
    OP_LBU  = 4'd5,
    OP_LHU  = 4'd6,
    OP_LWU  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_MISALIGNED  = 2'd1,
    FAULT_ILLEGAL     = 2'd2,
    FAULT_BUS_TIMEOUT = 2'd3
  } lsu_fault_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Access size in bytes; 0 for anything that does not touch memory.
  function automatic logic [3:0] op_size(lsu_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'd1;
      OP_LH, OP_LHU, OP_SH: return 4'd2;
      OP_LW, OP_LWU, OP_SW: return 4'd4;
      OP_LD, OP_SD:         return 4'd8;
      default:              return 4'd0;
    endcase
  endfunction

  function automatic logic op_is_signed(lsu_op_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic op_is_load(lsu_op_t op);
    return (op >= OP_LB) && (op <= OP_LWU);
  endfunction

  function automatic logic op_is_store(lsu_op_t op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  // Doubleword ops and LWU only exist on a 64-bit datapath.
  function automatic logic op_is_legal(lsu_op_t op, int xlen);
    if (op > OP_SD) return 1'b0;
    if ((xlen == 32) && ((op == OP_LD) || (op == OP_LWU) || (op == OP_SD))) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment shared by load/store paths.
//   op_i    - operation (selects size, signedness, store strobes)
//   off_i   - byte offset of the access inside an XLEN word
//   wdata_i - store data, low bytes significant
//   rwin_i  - read window {beat1, beat0}
//   wwin_o  - store data shifted into a two-word window
//   swin_o  - byte strobes for the two-word window (zero for non-stores)
//   rdata_o - extracted and extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_op_t                     op_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic [XLEN-1:0]             wdata_i,
  input  logic [2*XLEN-1:0]           rwin_i,
  output logic [2*XLEN-1:0]           wwin_o,
  output logic [2*XLEN/8-1:0]         swin_o,
  output logic [XLEN-1:0]             rdata_o
);

  localparam int NB = XLEN / 8;
  localparam int IW = $clog2(XLEN);

  int                  size;
  int                  nbits;
  logic [2*NB-1:0]     base;
  logic [XLEN-1:0]     lo;
  logic [XLEN-1:0]     mask;
  logic [IW-1:0]       msb_idx;
  logic                sign_bit;

  always_comb begin
    // NOTE: every variable gets a default before any conditional path so no latch is inferred.
    size     = int'(op_size(op_i));
    base     = '0;
    if (size > NB) size = NB;
    nbits    = size * 8;
    for (int i = 0; i < NB; i++) begin
      if (i < size) base[i] = 1'b1;
    end
    swin_o   = op_is_store(op_i) ? (base << off_i) : '0;
    wwin_o   = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};

    // Bring the addressed byte to bit 0, then keep only the access width.
    lo       = XLEN'(rwin_i >> {off_i, 3'b000});
    mask     = (nbits >= XLEN) ? '1 : ~({XLEN{1'b1}} << nbits);
    msb_idx  = (nbits > 0) ? IW'(nbits - 1) : '0;
    sign_bit = op_is_signed(op_i) && lo[msb_idx];
    rdata_o  = (lo & mask) | (sign_bit ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_accessor.sv
// lsu_accessor: load/store stage between executor and writeback.
//   clk, reset                    - clock, synchronous active-high reset
//   in_valid/in_ready, in_*       - request from the executor
//   out_valid/out_ready, out_*    - result to writeback (rd, data, fault)
//   mem_ready/mem_valid, mem_*    - aligned bus beats; mem_wstrb==0 is a read
// Misaligned accesses fault or split into two beats; a watchdog bounds each beat.
module lsu_accessor
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b0,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  input  logic [XLEN-1:0]     in_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_rd_data,
  output logic [1:0]          out_fault,
  output logic                mem_ready,
  input  logic                mem_valid,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WDW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata0_q, rdata0_d;
  logic [4:0]        rd_q, rd_d, out_rd_q, out_rd_d;
  logic [XLEN-1:0]   out_rd_data_q, out_rd_data_d;
  lsu_fault_t        out_fault_q, out_fault_d;
  logic              split_q, split_d, mem_ready_q, mem_ready_d;
  logic [WDW-1:0]    wdog_q, wdog_d;

  // Decode of the incoming request.
  lsu_op_t           in_op_e;
  logic [OFFW-1:0]   in_off;
  logic [3:0]        in_size;
  logic              in_misal, in_split;

  assign in_op_e  = lsu_op_t'(in_op);
  assign in_off   = in_addr[OFFW-1:0];
  assign in_size  = op_size(in_op_e);
  assign in_misal = (in_size != 4'd0) && (|(in_off & OFFW'(in_size - 4'd1)));
  assign in_split = (int'(in_off) + int'(in_size)) > NB;

  // Alignment for the registered request. The read window is {beat1, beat0};
  // for a single beat the upper word is zero.
  logic              beat1;
  logic [2*XLEN-1:0] rwin, wwin;
  logic [2*NB-1:0]   swin;
  logic [XLEN-1:0]   ld_result;
  logic [XLEN-1:0]   aligned_addr;

  assign beat1        = (state_q == ST_BEAT1);
  assign rwin         = beat1 ? {mem_rdata, rdata0_q} : {{XLEN{1'b0}}, mem_rdata};
  assign aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  lsu_align #(.XLEN(XLEN)) u_align (
    .op_i    (op_q),
    .off_i   (addr_q[OFFW-1:0]),
    .wdata_i (wdata_q),
    .rwin_i  (rwin),
    .wwin_o  (wwin),
    .swin_o  (swin),
    .rdata_o (ld_result)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    rdata0_d      = rdata0_q;
    split_d       = split_q;
    mem_ready_d   = mem_ready_q;
    wdog_d        = wdog_q;
    out_rd_d      = out_rd_q;
    out_rd_data_d = out_rd_data_q;
    out_fault_d   = out_fault_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d          = in_op_e;
          addr_d        = in_addr;
          wdata_d       = in_wdata;
          rd_d          = in_rd;
          split_d       = in_split;
          out_rd_d      = '0;
          out_rd_data_d = '0;
          out_fault_d   = FAULT_NONE;
          if (in_op_e == OP_NONE) begin
            out_rd_d      = in_rd;
            out_rd_data_d = in_rd_data;
            state_d       = ST_RESP;
          end else if (!op_is_legal(in_op_e, XLEN)) begin
            out_fault_d = FAULT_ILLEGAL;
            state_d     = ST_RESP;
          end else if (in_misal && !ALLOW_MISALIGNED) begin
            out_fault_d = FAULT_MISALIGNED;
            state_d     = ST_RESP;
          end else begin
            mem_ready_d = 1'b1;
            wdog_d      = '0;
            state_d     = ST_BEAT0;
          end
        end
      end

      ST_BEAT0, ST_BEAT1: begin
        if (!mem_ready_q) begin
          // Single idle cycle between split beats, then open beat 1.
          mem_ready_d = 1'b1;
          wdog_d      = '0;
        end else if (mem_valid) begin
          // A beat completing on the watchdog's last cycle still wins.
          mem_ready_d = 1'b0;
          if (!beat1 && split_q) begin
            rdata0_d = mem_rdata;
            state_d  = ST_BEAT1;
          end else begin
            out_rd_d      = op_is_load(op_q) ? rd_q : 5'd0;
            out_rd_data_d = op_is_load(op_q) ? ld_result : '0;
            out_fault_d   = FAULT_NONE;
            state_d       = ST_RESP;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WD_LAST)) begin
          mem_ready_d   = 1'b0;
          out_rd_d      = '0;
          out_rd_data_d = '0;
          out_fault_d   = FAULT_BUS_TIMEOUT;
          state_d       = ST_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin  // ST_RESP
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NONE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      rdata0_q      <= '0;
      split_q       <= 1'b0;
      mem_ready_q   <= 1'b0;
      wdog_q        <= '0;
      out_rd_q      <= '0;
      out_rd_data_q <= '0;
      out_fault_q   <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      rdata0_q      <= rdata0_d;
      split_q       <= split_d;
      mem_ready_q   <= mem_ready_d;
      wdog_q        <= wdog_d;
      out_rd_q      <= out_rd_d;
      out_rd_data_q <= out_rd_data_d;
      out_fault_q   <= out_fault_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE) && !reset;
  assign out_valid   = (state_q == ST_RESP);
  assign out_rd      = out_rd_q;
  assign out_rd_data = out_rd_data_q;
  assign out_fault   = out_fault_q;

  // Bus outputs are quiet (zero) whenever no beat is requested.
  assign mem_ready = mem_ready_q;
  assign mem_addr  = !mem_ready_q ? '0 : (beat1 ? aligned_addr + XLEN'(NB) : aligned_addr);
  assign mem_wstrb = !mem_ready_q ? '0 : (beat1 ? swin[2*NB-1:NB] : swin[NB-1:0]);
  assign mem_wdata = !mem_ready_q ? '0 : (beat1 ? wwin[2*XLEN-1:XLEN] : wwin[XLEN-1:0]);

endmodule

// File: tb/tb_lsu_accessor.sv
// Self-checking bench for lsu_accessor (XLEN=32). Two instances share the
// stimulus: dut_a faults misaligned accesses, dut_m splits them. Both use a
// four-cycle watchdog. Expected results go into a scoreboard queue when a
// request is issued and are compared when the selected DUT responds.
module tb_lsu_accessor;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  lsu_op_t     in_op;
  logic [31:0] in_addr, in_wdata, in_rd_data, mem_rdata;
  logic [4:0]  in_rd;
  logic        out_ready, mem_valid;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_mem_ready;
  logic [4:0]  a_out_rd;
  logic [31:0] a_out_rd_data, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_out_fault;
  logic [3:0]  a_mem_wstrb;
  logic        m_in_ready, m_out_valid, m_mem_ready;
  logic [4:0]  m_out_rd;
  logic [31:0] m_out_rd_data, m_mem_addr, m_mem_wdata;
  logic [1:0]  m_out_fault;
  logic [3:0]  m_mem_wstrb;

  logic        in_ready, out_valid, mem_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_data, mem_addr, mem_wdata;
  logic [1:0]  out_fault;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  lsu_accessor #(.XLEN(32), .ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_rd_data(in_rd_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_rd(a_out_rd), .out_rd_data(a_out_rd_data), .out_fault(a_out_fault),
    .mem_ready(a_mem_ready), .mem_valid(mem_valid), .mem_addr(a_mem_addr),
    .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_accessor #(.XLEN(32), .ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_rd_data(in_rd_data), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_rd(m_out_rd), .out_rd_data(m_out_rd_data), .out_fault(m_out_fault),
    .mem_ready(m_mem_ready), .mem_valid(mem_valid), .mem_addr(m_mem_addr),
    .mem_wstrb(m_mem_wstrb), .mem_wdata(m_mem_wdata), .mem_rdata(mem_rdata)
  );

  always_comb begin
    in_ready    = sel ? m_in_ready    : a_in_ready;
    out_valid   = sel ? m_out_valid   : a_out_valid;
    out_rd      = sel ? m_out_rd      : a_out_rd;
    out_rd_data = sel ? m_out_rd_data : a_out_rd_data;
    out_fault   = sel ? m_out_fault   : a_out_fault;
    mem_ready   = sel ? m_mem_ready   : a_mem_ready;
    mem_addr    = sel ? m_mem_addr    : a_mem_addr;
    mem_wstrb   = sel ? m_mem_wstrb   : a_mem_wstrb;
    mem_wdata   = sel ? m_mem_wdata   : a_mem_wdata;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; mem_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic expect_resp(input logic [4:0] rd, input logic [31:0] data, input lsu_fault_t f);
    sb.push_back('{rd: rd, data: data, fault: f});
  endtask

  // Presents one request for a single edge; returns on the negedge after accept.
  task automatic send(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input logic [31:0] rdd);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd; in_rd_data = rdd;
    tick();
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
  endtask

  // Waits (bounded) for a bus request, checks it, holds it `delay` cycles, completes it.
  task automatic serve_beat(input logic [31:0] e_addr, input logic [3:0] e_strb,
                            input logic [31:0] e_wdata, input int delay,
                            input logic [31:0] rdata, input int max_wait);
    for (int i = 0; i < max_wait && !mem_ready; i++) tick();
    check("mem_ready_up", mem_ready, 1);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wstrb", mem_wstrb, e_strb);
    check("mem_wdata", mem_wdata, e_wdata);
    for (int d = 0; d < delay; d++) begin
      tick();
      check("mem_ready_hold", mem_ready, 1);
      check("mem_addr_hold", mem_addr, e_addr);
    end
    mem_valid = 1'b1; mem_rdata = rdata;
    tick();
    mem_valid = 1'b0; mem_rdata = '0;
    check("mem_ready_drop", mem_ready, 0);
  endtask

  task automatic collect(input int max_wait);
    exp_t e;
    for (int i = 0; i < max_wait && !out_valid; i++) tick();
    check("out_valid", out_valid, 1);
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out_rd", out_rd, e.rd);
      check("out_rd_data", out_rd_data, e.data);
      check("out_fault", out_fault, e.fault);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cnt;
    sel = 1'b0; reset = 1'b1; in_valid = 1'b0; in_op = OP_NONE; in_addr = '0;
    in_wdata = '0; in_rd = '0; in_rd_data = '0; out_ready = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_rd_data", out_rd_data, 0);
    check("rst_out_fault", out_fault, 0);
    reset = 1'b0;
    tick();

    // ---- Instance with misaligned faults ----
    // Aligned word store; bus completes on the fourth wait cycle.
    expect_resp(5'd0, 32'h0, FAULT_NONE);
    send(OP_SW, 32'h100, 32'hDEADBEEF, 5'd9, 32'h0);
    serve_beat(32'h100, 4'hF, 32'hDEADBEEF, 3, 32'h0, 2);
    collect(2);

    // Byte loads, signed and unsigned, top byte lane.
    expect_resp(5'd3, 32'hFFFFFF80, FAULT_NONE);
    send(OP_LB, 32'h203, 32'h0, 5'd3, 32'h0);
    serve_beat(32'h200, 4'h0, 32'h0, 1, 32'h80FF0000, 2);
    collect(2);
    expect_resp(5'd3, 32'h00000080, FAULT_NONE);
    send(OP_LBU, 32'h203, 32'h0, 5'd3, 32'h0);
    serve_beat(32'h200, 4'h0, 32'h0, 0, 32'h80FF0000, 2);
    collect(2);

    // Pass-through, misaligned fault and illegal op: no bus activity.
    expect_resp(5'd7, 32'h12345678, FAULT_NONE);
    send(OP_NONE, 32'h55, 32'h0, 5'd7, 32'h12345678);
    check("none_no_bus", mem_ready, 0);
    collect(0);
    expect_resp(5'd0, 32'h0, FAULT_MISALIGNED);
    send(OP_SH, 32'h101, 32'hBEEF, 5'd4, 32'h0);
    check("misal_no_bus", mem_ready, 0);
    collect(0);
    check("misal_no_bus_after", mem_ready, 0);
    expect_resp(5'd0, 32'h0, FAULT_ILLEGAL);
    send(OP_LD, 32'h100, 32'h0, 5'd6, 32'h0);
    collect(0);

    // Watchdog expiry: mem_ready stays up exactly four cycles.
    expect_resp(5'd0, 32'h0, FAULT_BUS_TIMEOUT);
    send(OP_LW, 32'h300, 32'h0, 5'd8, 32'h0);
    cnt = 0;
    while (mem_ready && cnt < 20) begin
      cnt++;
      tick();
    end
    check("wdog_cycles", cnt, 4);
    collect(1);

    // mem_valid on the watchdog's last cycle completes normally.
    expect_resp(5'd8, 32'h01020304, FAULT_NONE);
    send(OP_LW, 32'h304, 32'h0, 5'd8, 32'h0);
    serve_beat(32'h304, 4'h0, 32'h0, 3, 32'h01020304, 0);
    collect(1);

    // Writeback stalls: result held, no new request accepted.
    expect_resp(5'd10, 32'hFFFFBEEF, FAULT_NONE);
    send(OP_LH, 32'h202, 32'h0, 5'd10, 32'h0);
    serve_beat(32'h200, 4'h0, 32'h0, 0, 32'hBEEF0000, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_rd_data", out_rd_data, 32'hFFFFBEEF);
      check("stall_rd", out_rd, 5'd10);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    collect(0);

    // Reset while a beat is pending drops the transaction.
    send(OP_LW, 32'h400, 32'h0, 5'd11, 32'h0);
    check("beat0_mem_ready", mem_ready, 1);
    reset = 1'b1;
    tick();
    check("rst_mid_mem_ready", mem_ready, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    check("rst_mid_recover", in_ready, 1);

    // ---- Instance that splits misaligned accesses ----
    do_reset();
    sel = 1'b1;
    expect_resp(5'd12, 32'h11223344, FAULT_NONE);
    send(OP_LW, 32'h102, 32'h0, 5'd12, 32'h0);
    serve_beat(32'h100, 4'h0, 32'h0, 1, 32'h3344AAAA, 0);
    serve_beat(32'h104, 4'h0, 32'h0, 0, 32'hBBBB1122, 1);
    collect(1);

    expect_resp(5'd0, 32'h0, FAULT_NONE);
    send(OP_SW, 32'h103, 32'hAABBCCDD, 5'd13, 32'h0);
    serve_beat(32'h100, 4'b1000, 32'hDD000000, 0, 32'h0, 0);
    serve_beat(32'h104, 4'b0111, 32'h00AABBCC, 2, 32'h0, 1);
    collect(1);

    // Misaligned but contained in one word: single beat.
    expect_resp(5'd0, 32'h0, FAULT_NONE);
    send(OP_SH, 32'h101, 32'h0000BEEF, 5'd14, 32'h0);
    serve_beat(32'h100, 4'b0110, 32'h00BEEF00, 0, 32'h0, 0);
    collect(1);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
